// File: rtl/debug_reg_reader.sv
// Debug register reader: resolves architectural registers through the rename map
// and returns their physical register file contents, one register or a full x0..x31 dump.
module debug_reg_reader #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned PREG_W   = 7,
    parameter int unsigned NUM_AREG = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_all,
    input  logic [4:0]        req_areg,
    output logic [4:0]        map_areg,
    input  logic [PREG_W-1:0] map_preg,
    output logic [PREG_W-1:0] prf_raddr,
    input  logic [XLEN-1:0]   prf_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [4:0]        rsp_areg,
    output logic [PREG_W-1:0] rsp_preg,
    output logic [XLEN-1:0]   rsp_data,
    output logic              rsp_last
);

    localparam int unsigned AREG_W    = 5;
    localparam logic [AREG_W-1:0] LAST_AREG = AREG_W'(NUM_AREG - 1);

    typedef enum logic [2:0] {
        IDLE,
        MAP,
        RADDR,
        RDATA,
        RESP
    } state_e;

    state_e              state_q,    state_d;
    logic [AREG_W-1:0]   cur_areg_q, cur_areg_d;
    logic                all_q,      all_d;
    logic [PREG_W-1:0]   preg_q,     preg_d;
    logic [XLEN-1:0]     data_q,     data_d;

    // State register; a synchronous reset drops any in-flight request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cur_areg_q <= '0;
            all_q      <= 1'b0;
            preg_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            cur_areg_q <= cur_areg_d;
            all_q      <= all_d;
            preg_q     <= preg_d;
            data_q     <= data_d;
        end
    end

    // Next-state sequencing: map lookup, PRF address, PRF data, response handshake.
    always_comb begin
        state_d    = state_q;
        cur_areg_d = cur_areg_q;
        all_d      = all_q;
        preg_d     = preg_q;
        data_d     = data_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cur_areg_d = req_all ? '0 : req_areg;
                    all_d      = req_all;
                    state_d    = MAP;
                end
            end
            MAP: begin
                preg_d  = map_preg;
                state_d = RADDR;
            end
            RADDR: begin
                state_d = RDATA;
            end
            RDATA: begin
                // x0 reads as zero regardless of what the PRF holds.
                data_d  = (cur_areg_q == '0) ? '0 : prf_rdata;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    if (all_q && (cur_areg_q != LAST_AREG)) begin
                        cur_areg_d = cur_areg_q + AREG_W'(1);
                        state_d    = MAP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode directly from registered state, so they hold steady under backpressure.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_last  = 1'b0;
        prf_raddr = '0;
        map_areg  = cur_areg_q;
        rsp_areg  = cur_areg_q;
        rsp_preg  = preg_q;
        rsp_data  = data_q;

        if (state_q == IDLE) begin
            req_ready = 1'b1;
        end else begin
            prf_raddr = preg_q;
        end

        if (state_q == RESP) begin
            rsp_valid = 1'b1;
            rsp_last  = !all_q || (cur_areg_q == LAST_AREG);
        end
    end

endmodule

// File: tb/tb_debug_reg_reader.sv
// Randomized bench for debug_reg_reader: rename map and PRF modelled as arrays,
// expected responses built per request from those arrays.
module tb_debug_reg_reader;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned PREG_W = 7;
    localparam int unsigned NREG   = 32;
    localparam int unsigned NPREG  = 1 << PREG_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_all;
    logic [4:0]        req_areg;
    logic [4:0]        map_areg;
    logic [PREG_W-1:0] map_preg;
    logic [PREG_W-1:0] prf_raddr;
    logic [XLEN-1:0]   prf_rdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [4:0]        rsp_areg;
    logic [PREG_W-1:0] rsp_preg;
    logic [XLEN-1:0]   rsp_data;
    logic              rsp_last;

    typedef struct {
        logic [4:0]        areg;
        logic [PREG_W-1:0] preg;
        logic [XLEN-1:0]   data;
        logic              last;
    } rsp_t;

    logic [PREG_W-1:0] map_mem [NREG];
    logic [XLEN-1:0]   prf_mem [NPREG];
    rsp_t              exp_q [$];

    int checks   = 0;
    int failures = 0;

    debug_reg_reader #(
        .XLEN    (XLEN),
        .PREG_W  (PREG_W),
        .NUM_AREG(NREG)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_all  (req_all),
        .req_areg (req_areg),
        .map_areg (map_areg),
        .map_preg (map_preg),
        .prf_raddr(prf_raddr),
        .prf_rdata(prf_rdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_areg (rsp_areg),
        .rsp_preg (rsp_preg),
        .rsp_data (rsp_data),
        .rsp_last (rsp_last)
    );

    always #5 clk = ~clk;

    // Rename map is a combinational lookup; the PRF answers one cycle after the address.
    assign map_preg = map_mem[map_areg];
    always @(posedge clk) prf_rdata <= prf_mem[prf_raddr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_mems();
        for (int i = 0; i < NREG; i++) map_mem[i] = PREG_W'($urandom);
        for (int p = 0; p < NPREG; p++) prf_mem[p] = $urandom;
    endtask

    task automatic build_expect(input logic all, input logic [4:0] areg);
        rsp_t r;
        int   first;
        int   last;
        first = all ? 0 : int'(areg);
        last  = all ? NREG - 1 : int'(areg);
        for (int i = first; i <= last; i++) begin
            r.areg = 5'(i);
            r.preg = map_mem[i];
            r.data = (i == 0) ? '0 : prf_mem[map_mem[i]];
            r.last = !all || (i == NREG - 1);
            exp_q.push_back(r);
        end
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            check("idle_no_rsp", 64'(rsp_valid), 64'd0);
            tick();
        end
    endtask

    // ready_mode: 0 = ready held high, 1 = random, 2 = stall 5 cycles per response.
    task automatic run_request(input logic all, input logic [4:0] areg, input int ready_mode,
                               input bit busy_pulse, input int abort_at);
        int          k;
        int          n;
        int          stall;
        bit          seen;
        bit          stalled;
        logic        r;
        logic [63:0] snap;

        check("req_ready_idle", 64'(req_ready), 64'd1);
        build_expect(all, areg);
        n = exp_q.size();
        req_valid = 1'b1;
        req_all   = all;
        req_areg  = areg;
        tick();
        req_valid = 1'b0;
        req_all   = 1'($urandom);
        req_areg  = 5'($urandom);

        k = 0; stall = 0; seen = 1'b0; stalled = 1'b0; snap = '0;
        while (exp_q.size() > 0 && k < 4 * NREG * 20) begin
            req_valid = busy_pulse && (k == 2);
            if (busy_pulse) req_areg = 5'd5;
            if (rsp_valid) begin
                if (!seen) begin
                    check("latency", 64'(k), 64'd3);
                    seen = 1'b1;
                end
                if (abort_at >= 0 && int'(rsp_areg) == abort_at) begin
                    reset     = 1'b0;
                    rsp_ready = 1'b0;
                    tick();
                    check("abort_valid", 64'(rsp_valid), 64'd0);
                    check("abort_ready", 64'(req_ready), 64'd1);
                    check("abort_last", 64'(rsp_last), 64'd0);
                    check("abort_data", 64'(rsp_data), 64'd0);
                    exp_q.delete();
                    return;
                end
                check("rsp_areg", 64'(rsp_areg), 64'(exp_q[0].areg));
                check("rsp_preg", 64'(rsp_preg), 64'(exp_q[0].preg));
                check("rsp_data", 64'(rsp_data), 64'(exp_q[0].data));
                check("rsp_last", 64'(rsp_last), 64'(exp_q[0].last));
                if (stalled)
                    check("stall_hold", {19'd0, rsp_areg, rsp_preg, rsp_data, rsp_last}, snap);
                case (ready_mode)
                    0:       r = 1'b1;
                    2:       r = (stall >= 5);
                    default: r = 1'($urandom_range(0, 1));
                endcase
                stall++;
            end else begin
                check("busy_not_ready", 64'(req_ready), 64'd0);
                r = 1'($urandom_range(0, 1));
            end
            rsp_ready = r;
            stalled   = rsp_valid && !r;
            snap      = {19'd0, rsp_areg, rsp_preg, rsp_data, rsp_last};
            if (rsp_valid && r) begin
                void'(exp_q.pop_front());
                stall = 0;
            end
            tick();
            k++;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check("responses_done", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        if (ready_mode == 0) check("total_cycles", 64'(k), 64'(4 * n));
        check("end_ready", 64'(req_ready), 64'd1);
        check("end_valid", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_all   = 1'b0;
        req_areg  = '0;
        rsp_ready = 1'b0;
        randomize_mems();
        tick();
        tick();
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_last", 64'(rsp_last), 64'd0);
        check("rst_rsp_areg", 64'(rsp_areg), 64'd0);
        check("rst_rsp_preg", 64'(rsp_preg), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_map_areg", 64'(map_areg), 64'd0);
        check("rst_prf_raddr", 64'(prf_raddr), 64'd0);
        reset = 1'b1;

        // Single read, accepted on the first edge out of reset.
        map_mem[28] = 7'd45;
        prf_mem[45] = 32'h0000_00AB;
        run_request(1'b0, 5'd28, 0, 1'b0, -1);

        // x0 always reads zero.
        map_mem[0] = 7'd3;
        prf_mem[3] = 32'hDEAD_BEEF;
        run_request(1'b0, 5'd0, 0, 1'b0, -1);

        // Full dump with a known pattern.
        for (int i = 0; i < NREG; i++) map_mem[i] = PREG_W'(i + 32);
        for (int p = 0; p < NPREG; p++) prf_mem[p] = 32'(p * 4);
        run_request(1'b1, 5'd0, 0, 1'b0, -1);

        // Backpressure on a single read and across a dump.
        randomize_mems();
        run_request(1'b0, 5'd17, 2, 1'b0, -1);
        run_request(1'b1, 5'd0, 2, 1'b0, -1);

        // A request pulsed while busy must be dropped.
        randomize_mems();
        run_request(1'b0, 5'd9, 0, 1'b1, -1);
        idle_check(6);

        // Reset during a dump, then a fresh single read.
        randomize_mems();
        run_request(1'b1, 5'd0, 0, 1'b0, 10);
        reset = 1'b1;
        run_request(1'b0, 5'd29, 0, 1'b0, -1);

        // Random traffic with random consumer stalls.
        for (int t = 0; t < 40; t++) begin
            randomize_mems();
            run_request(1'($urandom_range(0, 7) == 0), 5'($urandom), 1, 1'b0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
